// File: rtl/shift_pkg.sv
// Shared types and constants for the serial deserializer.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_out_buf.sv
// One-entry valid/ready holding register for finished words; flags a
// completed word that arrives while the held word is still unconsumed.
module shift_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             perr_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             perr_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        overrun_d = 1'b0;
        if (load_i) begin
            // A word being drained this cycle frees the slot for the new one.
            if (!valid_q || ready_i) begin
                data_d  = data_i;
                perr_d  = perr_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver, MSB- or LSB-first, with a one-word output buffer.
// Define PARITY_CHECK_EN to append and check an even-parity bit after each word.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin,
    input  logic             sin_start,
    input  logic             msb_first,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             sync_err,
    output logic             parity_err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             sync_err_q, sync_err_d;

    logic [WIDTH-1:0] sreg_shift;
    logic [WIDTH-1:0] sreg_first;
    logic [WIDTH-1:0] word_d;
    logic             done_d;
    logic             perr_d;
    logic             buf_perr;

    assign sreg_shift = (dir_q == DIR_MSB) ? {sreg_q[WIDTH-2:0], sin}
                                           : {sin, sreg_q[WIDTH-1:1]};
    assign sreg_first = (msb_first == DIR_MSB) ? {{(WIDTH-1){1'b0}}, sin}
                                               : {sin, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        sync_err_d = 1'b0;
        done_d     = 1'b0;
        perr_d     = 1'b0;
        word_d     = sreg_shift;
        if (sin_valid && sin_start) begin
            // A start always opens a fresh frame, discarding any partial one.
            sync_err_d = (state_q != IDLE);
            state_d    = SHIFT;
            sreg_d     = sreg_first;
            dir_d      = msb_first;
            cnt_d      = CNT_W'(1);
        end else if (sin_valid) begin
            case (state_q)
                SHIFT: begin
                    sreg_d = sreg_shift;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
                        cnt_d   = CNT_W'(WIDTH);
`else
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    word_d  = sreg_q;
                    perr_d  = (^sreg_q) ^ sin;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            dir_q      <= DIR_LSB;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            sync_err_q <= sync_err_d;
        end
    end

    shift_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .load_i   (done_d),
        .data_i   (word_d),
        .perr_i   (perr_d),
        .ready_i  (out_ready),
        .data_o   (out),
        .valid_o  (out_valid),
        .perr_o   (buf_perr),
        .overrun_o(overrun)
    );

`ifdef PARITY_CHECK_EN
    assign parity_err = buf_perr;
`else
    assign parity_err = 1'b0;
`endif

    assign busy     = (state_q != IDLE);
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: table of frames plus hand-written
// overrun, resync, reset and parity sequences.
module tb_shift_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin_valid = 1'b0;
    logic       sin = 1'b0;
    logic       sin_start = 1'b0;
    logic       msb_first = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       overrun;
    logic       sync_err;
    logic       parity_err;

    int tests = 0;
    int fails = 0;
    int sync_cnt = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    shift_deserializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin_valid (sin_valid),
        .sin       (sin),
        .sin_start (sin_start),
        .msb_first (msb_first),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun),
        .sync_err  (sync_err),
        .parity_err(parity_err)
    );

    always @(negedge clk) begin
        if (sync_err) sync_cnt++;
        if (overrun)  ovr_cnt++;
    end

    typedef struct {
        logic       msb;
        logic [7:0] seq;   // serial bits in send order, seq[7] first
        int         gap;
        logic       pbit;
        logic [7:0] exp_out;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic st, input logic m);
        sin_valid = 1'b1;
        sin       = b;
        sin_start = st;
        msb_first = m;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin_start = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] seq, input logic m, input int gap, input logic pbit);
        for (int i = 0; i < 8; i++) begin
            drive_bit(seq[7-i], (i == 0), m);
`ifdef PARITY_CHECK_EN
            check("busy_mid", busy, 1);
            for (int g = 0; g < gap; g++) idle_cycle();
`else
            if (i < 7) begin
                check("busy_mid", busy, 1);
                for (int g = 0; g < gap; g++) begin
                    idle_cycle();
                    check("busy_gap", busy, 1);
                end
            end
`endif
        end
`ifdef PARITY_CHECK_EN
        drive_bit(pbit, 1'b0, m);
`else
        if (pbit === 1'bx) $display("[TB] parity bit unused");
`endif
    endtask

    vec_t vecs[8];
    int   sync0;
    int   ovr0;

    initial begin
        vecs[0] = '{1'b1, 8'hFD, 0, 1'b1, 8'hFD};
        vecs[1] = '{1'b0, 8'hBF, 2, 1'b1, 8'hFD};
        vecs[2] = '{1'b1, 8'h81, 0, 1'b0, 8'h81};
        vecs[3] = '{1'b0, 8'h80, 0, 1'b1, 8'h01};
        vecs[4] = '{1'b0, 8'h01, 1, 1'b1, 8'h80};
        vecs[5] = '{1'b1, 8'h00, 1, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'hF0, 0, 1'b0, 8'h0F};
        vecs[7] = '{1'b0, 8'hC8, 3, 1'b1, 8'h13};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sync", sync_err, 0);
        check("rst_perr", parity_err, 0);
        rst = 1'b0;
        idle_cycle();

        // Bits without a start are ignored in IDLE.
        drive_bit(1'b1, 1'b0, 1'b1);
        check("idle_ignore_busy", busy, 0);

        for (int v = 0; v < 8; v++) begin
            send_seq(vecs[v].seq, vecs[v].msb, vecs[v].gap, vecs[v].pbit);
            check("vec_valid", out_valid, 1);
            check("vec_out", out, vecs[v].exp_out);
            check("vec_perr", parity_err, 0);
            check("vec_busy_end", busy, 0);
            idle_cycle();
            check("vec_valid_drop", out_valid, 0);
        end

        // Overrun: second frame completes while the first is still held.
        out_ready = 1'b0;
        ovr0 = ovr_cnt;
        send_seq(8'hFD, 1'b1, 0, 1'b1);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_flag", overrun, 0);
        send_seq(8'h7E, 1'b1, 0, 1'b0);
        check("ovr_pulse", overrun, 1);
        check("ovr_hold_out", out, 8'hFD);
        check("ovr_hold_valid", out_valid, 1);
        idle_cycle();
        check("ovr_pulse_end", overrun, 0);
        check("ovr_count", ovr_cnt - ovr0, 1);
        out_ready = 1'b1;
        idle_cycle();
        check("ovr_drain", out_valid, 0);
        send_seq(8'hFA, 1'b1, 0, 1'b0);
        check("ovr_next_out", out, 8'hFA);
        check("ovr_next_valid", out_valid, 1);
        idle_cycle();

        // Resync: start + 3 bits, then a fresh full frame.
        sync0 = sync_cnt;
        drive_bit(1'b0, 1'b1, 1'b1);
        drive_bit(1'b1, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 1'b0, 1'b1);
        check("sync_none_yet", sync_cnt - sync0, 0);
        send_seq(8'hFB, 1'b1, 0, 1'b0);
        check("sync_count", sync_cnt - sync0, 1);
        check("sync_out", out, 8'hFB);
        check("sync_valid", out_valid, 1);
        idle_cycle();

        // Reset mid-frame with a word still held.
        out_ready = 1'b0;
        send_seq(8'hFD, 1'b1, 0, 1'b1);
        check("prerst_valid", out_valid, 1);
        sync0 = sync_cnt;
        ovr0  = ovr_cnt;
        for (int i = 0; i < 5; i++) drive_bit(1'b1, (i == 0), 1'b0);
        rst = 1'b1;
        #1;
        check("arst_out", out, 0);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        idle_cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        check("arst_no_sync", sync_cnt - sync0, 0);
        check("arst_no_ovr", ovr_cnt - ovr0, 0);
        send_seq(8'hFE, 1'b1, 0, 1'b1);
        check("postrst_out", out, 8'hFE);
        check("postrst_valid", out_valid, 1);
        idle_cycle();

`ifdef PARITY_CHECK_EN
        send_seq(8'hFD, 1'b1, 0, 1'b1);
        check("par_ok_valid", out_valid, 1);
        check("par_ok_perr", parity_err, 0);
        idle_cycle();
        send_seq(8'hFD, 1'b1, 0, 1'b0);
        check("par_bad_valid", out_valid, 1);
        check("par_bad_out", out, 8'hFD);
        check("par_bad_perr", parity_err, 1);
        idle_cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Serial-in/parallel-out receiver: the receiving end of a serial link driven by a shiftU-based parallel-to-serial transmitter.
- Rebuilds WIDTH-bit words from a strobed bit stream, either MSB-first or LSB-first.
- Uses the same shift directions as the shift unit: left-shift with LSB fill, or right-shift with MSB fill.
- Presents each finished word on a valid/ready output held in a one-entry buffer, so the next frame can be received while the current word waits.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sin_valid  input  1  a serial bit is present this cycle.
- sin  input  1  serial data bit.
- sin_start  input  1  qualifies the first bit of a frame; only meaningful when sin_valid=1.
- msb_first  input  1  bit order: 1=MSB-first, 0=LSB-first. Sampled only on the start bit.
- out  output  WIDTH  assembled word.
- out_valid  output  1  out holds an unconsumed word.
- out_ready  input  1  consumer accepts out.
- busy  output  1  a frame is in progress.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.
- sync_err  output  1  one-cycle pulse: a partial frame was discarded by a new start.
- parity_err  output  1  parity flag qualified by out_valid; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; out, shift register and counter all 0; out_valid, busy, overrun, sync_err, parity_err all 0.
- IDLE state:
  - Ignores bits without sin_start.
  - On sin_valid & sin_start: captures bit 0 of the frame, latches the direction from msb_first, sets count=1, moves to SHIFT.
- SHIFT state:
  - Each sin_valid adds one bit. MSB-first: sreg <= {sreg[WIDTH-2:0], sin}. LSB-first: sreg <= {sin, sreg[WIDTH-1:1]}.
  - Cycles with sin_valid=0 hold all state; gaps of any length are allowed.
  - When the WIDTH-th bit is accepted, the frame is complete and the state returns to IDLE.
  - A start bit on the same cycle as the completing bit is not possible, because the completing bit is not a start.
- Start bit during SHIFT: the partial frame is discarded, sync_err pulses, and the start bit counts as bit 0 of the new frame. Direction is re-sampled.
- busy is 1 while in SHIFT (and PARITY, when present).
- Latency: out and out_valid update on the clock edge that accepts the last bit, so they are visible in the next cycle.
- Output handshake: a transfer occurs when out_valid & out_ready. out and out_valid are stable while out_valid=1 and out_ready=0.
- Completion while the buffer is full:
  - Buffer empty, or being consumed this cycle: load the new word; out_valid=1.
  - Buffer full and not consumed: drop the new word, pulse overrun; out and out_valid are unchanged.
- Reset mid-frame: the partial frame is lost and there is no error pulse.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined:
  - Frame is WIDTH data bits plus one even-parity bit; state PARITY follows SHIFT.
  - Completion is on the parity bit. parity_err = (^data) ^ parity_bit, loaded together with out.
  - A start bit during PARITY resyncs as in SHIFT.
  - overrun rules apply at the parity bit.
- Undefined: no PARITY state; frame is WIDTH bits; parity_err is constant 0.

Decomposition:
- Package shift_pkg:
  - State enum {IDLE, SHIFT, PARITY}.
  - DIR_LSB=1'b0, DIR_MSB=1'b1.
  - Default WIDTH constant.
- Sub-module shift_out_buf: one-entry valid/ready holding register for out, parity_err and overrun detection.

Test Plan:
- MSB-first, bits 1,1,1,1,1,1,0,1 back-to-back, out_ready=1 -> out=8'hFD, out_valid=1 for one cycle, beginning the cycle after bit 8.
- LSB-first, bits 1,0,1,1,1,1,1,1 with 2-cycle gaps between sin_valid strobes -> out=8'hFD; busy=1 from the start bit until the last bit.
- out_ready=0, frame 8'hFD then frame 8'h7E -> overrun pulses once at the end of the second frame; out stays 8'hFD. Then out_ready=1 -> out_valid drops; the next frame 8'hFA is delivered.
- Start, 3 bits, then a new start followed by a full 8'hFB frame -> sync_err pulses once; out=8'hFB.
- rst asserted after 5 bits, then released -> all outputs 0 immediately; the following clean frame 8'hFE is received correctly.
- PARITY_CHECK_EN defined:
  - 8'hFD followed by parity bit 1 -> parity_err=0.
  - 8'hFD followed by parity bit 0 -> parity_err=1 with out_valid.
